// File: rtl/uart_baud_switch_ctrl.sv
// Run-time baud-rate switch sequencer: quiesces the TX/RX engines, waits for them to drain,
// updates baudrate_sel, then lets the generator settle for a fixed number of uart_clock ticks.
module uart_baud_switch_ctrl #(
    parameter int unsigned SETTLE_TICKS   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [1:0]  DEFAULT_SEL    = 2'd0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    output logic       done,
    output logic       error,
    input  logic       tx_busy,
    input  logic       rx_busy,
    input  logic       uart_clock,
    output logic       quiesce,
    output logic [1:0] baudrate_sel
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ST_W = $clog2(SETTLE_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX    = '1;
    localparam logic [ST_W-1:0] ST_TARGET = ST_W'(SETTLE_TICKS);
    localparam logic [ST_W-1:0] ST_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_SWITCH,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      baud_sel_q, baud_sel_d;
    logic [TO_W-1:0] timeout_q, timeout_d;
    logic [1:0]      idle_q, idle_d;
    logic [ST_W-1:0] settle_q, settle_d;
    logic [ST_W-1:0] settle_inc;
    logic            uart_clock_q, uart_clock_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic accept;
    logic tick;
    logic engines_idle;

    assign req_ready    = (state_q == S_IDLE);
    assign accept       = req_valid && req_ready;
    assign tick         = uart_clock && !uart_clock_q;
    assign engines_idle = !tx_busy && !rx_busy;
    assign settle_inc   = (settle_q == ST_MAX) ? settle_q : settle_q + ST_W'(1);

    assign quiesce      = (state_q == S_DRAIN) || (state_q == S_SWITCH) || (state_q == S_SETTLE);
    assign done         = done_q;
    assign error        = error_q;
    assign baudrate_sel = baud_sel_q;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        baud_sel_d   = baud_sel_q;
        timeout_d    = timeout_q;
        idle_d       = idle_q;
        settle_d     = settle_q;
        uart_clock_d = uart_clock;
        done_d       = 1'b0;
        error_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sel_d = req_sel;
                    if (req_sel == baud_sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = S_DRAIN;
                        timeout_d = '0;
                        idle_d    = '0;
                    end
                end
            end
            S_DRAIN: begin
                timeout_d = (timeout_q == TO_MAX) ? timeout_q : timeout_q + TO_W'(1);
                if (engines_idle) begin
                    idle_d = (idle_q == 2'd3) ? idle_q : idle_q + 2'd1;
                end else begin
                    idle_d = '0;
                end
                // Second consecutive idle cycle switches, even if the timeout expires on the same cycle.
                if (engines_idle && (idle_q != 2'd0)) begin
                    state_d = S_SWITCH;
                end else if (timeout_q == TO_LAST) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end
            end
            S_SWITCH: begin
                baud_sel_d = sel_q;
                settle_d   = '0;
                state_d    = S_SETTLE;
            end
            S_SETTLE: begin
                if (tick) begin
                    settle_d = settle_inc;
                    if (settle_inc == ST_TARGET) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            baud_sel_q   <= DEFAULT_SEL;
            timeout_q    <= '0;
            idle_q       <= '0;
            settle_q     <= '0;
            uart_clock_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            baud_sel_q   <= baud_sel_d;
            timeout_q    <= timeout_d;
            idle_q       <= idle_d;
            settle_q     <= settle_d;
            uart_clock_q <= uart_clock_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

endmodule

// File: tb/tb_uart_baud_switch_ctrl.sv
// Directed bench for uart_baud_switch_ctrl; done/error pulses are predicted into a
// queue at stimulus time and matched cycle-exactly by a negedge monitor.
module tb_uart_baud_switch_ctrl;

    localparam int ST = 4;
    localparam int TO = 100;

    typedef struct {
        bit         is_done;
        int         cyc;
        logic [1:0] sel;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic       done;
    logic       error;
    logic       tx_busy;
    logic       rx_busy;
    logic       uart_clock;
    logic       quiesce;
    logic [1:0] baudrate_sel;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc;
    exp_t sb[$];
    exp_t e;

    uart_baud_switch_ctrl #(
        .SETTLE_TICKS  (ST),
        .TIMEOUT_CYCLES(TO),
        .DEFAULT_SEL   (2'd0)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_ready   (req_ready),
        .done        (done),
        .error       (error),
        .tx_busy     (tx_busy),
        .rx_busy     (rx_busy),
        .uart_clock  (uart_clock),
        .quiesce     (quiesce),
        .baudrate_sel(baudrate_sel)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] sel, output int acc_cyc);
        req_valid = 1'b1;
        req_sel   = sel;
        for (int i = 0; i < 20 && !req_ready; i++) waitCycles(1);
        checkOutput("ready_before_accept", req_ready, 1'b1);
        waitCycles(1);
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic uartPulses(input int n);
        for (int i = 0; i < n; i++) begin
            uart_clock = 1'b1;
            waitCycles(1);
            uart_clock = 1'b0;
            waitCycles(1);
        end
    endtask

    // Called right after the SWITCH cycle: the last tick lands 2*ST-1 edges later.
    task automatic doSettle(input logic [1:0] sel);
        exp_t x;
        x.is_done = 1'b1;
        x.cyc     = cyc + 2 * ST - 1;
        x.sel     = sel;
        sb.push_back(x);
        uartPulses(ST);
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checkOutput("missed_pulse_cycle", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checkOutput("done_pulse", done, e.is_done);
                checkOutput("error_pulse", error, !e.is_done);
                checkOutput("sel_at_pulse", baudrate_sel, e.sel);
                checkOutput("quiesce_at_pulse", quiesce, 1'b0);
            end else begin
                checkOutput("no_spurious_done", done, 1'b0);
                checkOutput("no_spurious_error", error, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t x;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_sel    = 2'd0;
        tx_busy    = 1'b0;
        rx_busy    = 1'b0;
        uart_clock = 1'b0;
        waitCycles(2);
        checkOutput("reset_sel", baudrate_sel, 2'd0);
        checkOutput("reset_ready", req_ready, 1'b1);
        checkOutput("reset_quiesce", quiesce, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_error", error, 1'b0);
        reset_n = 1'b1;
        waitCycles(2);

        $display("[TB] test 1: request at current rate");
        applyStimulus(2'd0, acc);
        x.is_done = 1'b1; x.cyc = acc; x.sel = 2'd0;
        sb.push_back(x);
        checkOutput("same_quiesce", quiesce, 1'b0);
        checkOutput("same_ready", req_ready, 1'b1);
        waitCycles(2);
        checkOutput("same_sel", baudrate_sel, 2'd0);

        $display("[TB] test 2: idle engines, switch to 2");
        applyStimulus(2'd2, acc);
        checkOutput("t2_quiesce_rise", quiesce, 1'b1);
        checkOutput("t2_ready_low", req_ready, 1'b0);
        waitCycles(2);
        checkOutput("t2_sel_before_switch", baudrate_sel, 2'd0);
        waitCycles(1);
        checkOutput("t2_sel_after_switch", baudrate_sel, 2'd2);
        checkOutput("t2_quiesce_settle", quiesce, 1'b1);
        doSettle(2'd2);
        checkOutput("t2_ready_after", req_ready, 1'b1);

        $display("[TB] test 3: busy engines, one-cycle idle gap");
        tx_busy = 1'b1;
        applyStimulus(2'd1, acc);
        for (int i = 0; i < 50; i++) begin
            rx_busy = i[0];
            waitCycles(1);
        end
        checkOutput("t3_sel_while_busy", baudrate_sel, 2'd2);
        checkOutput("t3_quiesce_busy", quiesce, 1'b1);
        tx_busy = 1'b0;
        rx_busy = 1'b0;
        waitCycles(1);
        tx_busy = 1'b1;
        waitCycles(3);
        checkOutput("t3_gap_no_switch", baudrate_sel, 2'd2);
        tx_busy = 1'b0;
        waitCycles(2);
        checkOutput("t3_sel_before_switch", baudrate_sel, 2'd2);
        waitCycles(1);
        checkOutput("t3_sel_after_switch", baudrate_sel, 2'd1);
        doSettle(2'd1);

        $display("[TB] test 4: drain timeout");
        rx_busy = 1'b1;
        applyStimulus(2'd3, acc);
        x.is_done = 1'b0; x.cyc = acc + TO; x.sel = 2'd1;
        sb.push_back(x);
        waitCycles(TO - 1);
        checkOutput("t4_quiesce_before_timeout", quiesce, 1'b1);
        checkOutput("t4_ready_before_timeout", req_ready, 1'b0);
        waitCycles(1);
        checkOutput("t4_quiesce_after_error", quiesce, 1'b0);
        checkOutput("t4_ready_after_error", req_ready, 1'b1);
        checkOutput("t4_sel_unchanged", baudrate_sel, 2'd1);
        rx_busy = 1'b0;
        waitCycles(2);

        $display("[TB] test 5: reset during settle");
        reset_n = 1'b0;
        #1;
        checkOutput("t5_reset_idle_sel", baudrate_sel, 2'd0);
        waitCycles(1);
        reset_n = 1'b1;
        waitCycles(1);
        applyStimulus(2'd1, acc);
        waitCycles(3);
        checkOutput("t5_sel_switched", baudrate_sel, 2'd1);
        uartPulses(2);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t5_async_sel", baudrate_sel, 2'd0);
        checkOutput("t5_async_quiesce", quiesce, 1'b0);
        checkOutput("t5_async_ready", req_ready, 1'b1);
        checkOutput("t5_async_done", done, 1'b0);
        waitCycles(1);
        reset_n = 1'b1;
        waitCycles(2);
        applyStimulus(2'd1, acc);
        waitCycles(3);
        checkOutput("t5_resel", baudrate_sel, 2'd1);
        doSettle(2'd1);

        $display("[TB] test 6: back-to-back requests with req_valid held");
        req_valid = 1'b1;
        req_sel   = 2'd1;
        waitCycles(1);
        x.is_done = 1'b1; x.cyc = cyc; x.sel = 2'd1;
        sb.push_back(x);
        req_sel = 2'd2;
        waitCycles(1);
        req_sel = 2'd3;
        checkOutput("t6_quiesce_2", quiesce, 1'b1);
        checkOutput("t6_ready_low_2", req_ready, 1'b0);
        waitCycles(2);
        checkOutput("t6_sel_hold_1", baudrate_sel, 2'd1);
        waitCycles(1);
        checkOutput("t6_sel_2", baudrate_sel, 2'd2);
        checkOutput("t6_ready_low_settle", req_ready, 1'b0);
        doSettle(2'd2);
        checkOutput("t6_ready_idle", req_ready, 1'b1);
        waitCycles(1);
        req_valid = 1'b0;
        checkOutput("t6_quiesce_3", quiesce, 1'b1);
        waitCycles(3);
        checkOutput("t6_sel_3", baudrate_sel, 2'd3);
        doSettle(2'd3);
        waitCycles(2);
        checkOutput("t6_final_sel", baudrate_sel, 2'd3);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
